// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// sequencer states and the byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: store replication/byte enables and load
// byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        st_size_i,
  input  logic [1:0]        st_off_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [3:0]        st_be_o,
  output logic [DATA_W-1:0] st_data_o,
  input  logic [2:0]        ld_fun3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [DATA_W-1:0] ld_word_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    st_be_o = lsu_byte_en(st_size_i, st_off_i);
    case (st_size_i)
      2'b00:   st_data_o = {4{st_data_i[7:0]}};
      2'b01:   st_data_o = {2{st_data_i[15:0]}};
      default: st_data_o = st_data_i;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (ld_fun3_i)
      LB:      ld_data_o = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LBU:     ld_data_o = {{(DATA_W-8){1'b0}}, ld_byte};
      LH:      ld_data_o = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LHU:     ld_data_o = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: one req/gnt/rvalid access at a time,
// holding the pipeline until the response arrives.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        fun3_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              fault_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lsu_state_t        state_q, state_d;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        off_q;
  logic [2:0]        fun3_q;

  logic              access, ld_legal, st_legal, misal, legal, ok;
  logic              done;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_data, ld_data;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_size_i (fun3_i[1:0]),
    .st_off_i  (addr_i[1:0]),
    .st_data_i (wdata_i),
    .st_be_o   (st_be),
    .st_data_o (st_data),
    .ld_fun3_i (fun3_q),
    .ld_off_i  (off_q),
    .ld_word_i (mem_rdata_i),
    .ld_data_o (ld_data)
  );

  always_comb begin
    access   = (load_i | store_i) & ~flush_i;
    ld_legal = fun3_i inside {LB, LH, LW, LBU, LHU};
    st_legal = fun3_i inside {SB, SH, SW};
    misal    = ((fun3_i[1:0] == 2'b01) & addr_i[0]) |
               ((fun3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    legal    = (load_i ? ld_legal : st_legal) & ~(load_i & store_i) & ~misal;
    ok       = access & legal;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ok) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      fun3_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == REQ);
      // Bus fields are captured only on acceptance so they stay stable through REQ/WAIT.
      if (state_q == IDLE && ok) begin
        we_q    <= store_i;
        addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
        be_q    <= st_be;
        wdata_q <= st_data;
        off_q   <= addr_i[1:0];
        fun3_q  <= fun3_i;
      end
    end
  end

  always_comb begin
    done          = (state_q == WAIT) & mem_rvalid_i;
    stall_o       = ((state_q == IDLE) & ok) | (state_q == REQ) |
                    ((state_q == WAIT) & ~mem_rvalid_i);
    fault_o       = (state_q == IDLE) & access & ~legal;
    rdata_valid_o = done & ~we_q;
    rdata_o       = rdata_valid_o ? ld_data : '0;
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table driven through a bus-slave model,
// expected completions queued on acceptance and popped at rvalid.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_i, store_i, flush_i;
  logic [2:0]  fun3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rdata_valid_o, fault_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load_i),
    .store_i       (store_i),
    .fun3_i        (fun3_i),
    .flush_i       (flush_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .fault_o       (fault_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          gd, rd;
    logic        wflush, flt;
    logic [3:0]  be;
    logic [31:0] ewd, ead, erd;
  } vec_t;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] wd, ad;
    logic        we;
    logic [31:0] rd;
  } exp_t;

  vec_t tbl[14];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_i  = 1'b0;
    store_i = 1'b0;
    flush_i = 1'b0;
    fun3_i  = 3'b000;
    addr_i  = '0;
    wdata_i = '0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    load_i = v.ld; store_i = v.st; fun3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    flush_i = 1'b0;
    #1;
    if (v.flt) begin
      chk("fault", fault_o, 1);
      chk("fault_stall", stall_o, 0);
      chk("fault_noreq", mem_req_o, 0);
      tick();
      idle_inputs();
      #1;
      chk("fault_pulse", fault_o, 0);
      chk("fault_noreq_next", mem_req_o, 0);
    end else begin
      chk("accept_stall", stall_o, 1);
      chk("accept_fault", fault_o, 0);
      e = '{v.be, v.ewd, v.ead, v.st, v.erd};
      sbq.push_back(e);
      tick();
      idle_inputs();
      for (int k = 0; k <= v.gd; k++) begin
        mem_gnt_i = (k == v.gd);
        #1;
        chk("req", mem_req_o, 1);
        chk("req_stall", stall_o, 1);
        chk("be", mem_be_o, sbq[0].be);
        chk("addr", mem_addr_o, sbq[0].ad);
        chk("wdata", mem_wdata_o, sbq[0].wd);
        chk("we", mem_we_o, sbq[0].we);
        tick();
      end
      mem_gnt_i = 1'b0;
      for (int r = 0; r <= v.rd; r++) begin
        flush_i      = v.wflush;
        mem_rvalid_i = (r == v.rd);
        mem_rdata_i  = v.rdata;
        #1;
        chk("wait_req", mem_req_o, 0);
        if (r < v.rd) begin
          chk("wait_stall", stall_o, 1);
          chk("wait_valid", rdata_valid_o, 0);
        end else begin
          chk("done_stall", stall_o, 0);
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
          end else begin
            got = sbq.pop_front();
            chk("rdata_valid", rdata_valid_o, {31'b0, ~got.we});
            chk("rdata", rdata_o, got.rd);
          end
        end
        tick();
      end
      mem_rvalid_i = 1'b0;
      flush_i      = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ld st f3      addr      wdata         rdata         gd rd wf flt be       ewd           ead       erd
    tbl[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h55AA55AA, 0, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h100, 32'h0};
    tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 0, 0, 4'b1000, 32'h0,        32'h100, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 0, 0, 4'b1000, 32'h0,        32'h100, 32'h00000080};
    tbl[3]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 0, 0, 0, 0, 4'b1100, 32'h0,        32'h100, 32'h000080FF};
    tbl[4]  = '{0, 1, 3'b001, 32'h0A2, 32'h00001234, 32'h0,        0, 1, 0, 0, 4'b1100, 32'h12341234, 32'h0A0, 32'h0};
    tbl[5]  = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0};
    tbl[6]  = '{1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0};
    tbl[7]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 1, 0, 0, 0, 4'b1100, 32'h0,        32'h100, 32'hFFFF80FF};
    tbl[8]  = '{0, 1, 3'b000, 32'h201, 32'h123456AB, 32'h0,        0, 0, 0, 0, 4'b0010, 32'hABABABAB, 32'h200, 32'h0};
    tbl[9]  = '{1, 0, 3'b010, 32'h300, 32'h0,        32'hCAFEF00D, 3, 2, 1, 0, 4'b1111, 32'h0,        32'h300, 32'hCAFEF00D};
    tbl[10] = '{1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0};
    tbl[11] = '{0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0};
    tbl[12] = '{0, 1, 3'b001, 32'h0A1, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0};
    tbl[13] = '{1, 0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 0, 0, 0, 0, 4'b0001, 32'h0,        32'h100, 32'h0000007F};

    rst = 1'b1;
    idle_inputs();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_valid", rdata_valid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    tick();

    // Table vectors run back to back: each accept lands in the cycle after the previous completion.
    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // A flushed load is not an access: no fault, no stall, no request.
    load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h104; flush_i = 1'b1;
    #1;
    chk("flush_stall", stall_o, 0);
    chk("flush_fault", fault_o, 0);
    tick();
    idle_inputs();
    #1;
    chk("flush_noreq", mem_req_o, 0);
    tick();

    // Reset while waiting for rvalid, then a stray rvalid.
    load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h400;
    #1;
    chk("rstw_accept", stall_o, 1);
    tick();
    idle_inputs();
    mem_gnt_i = 1'b1;
    #1;
    chk("rstw_req", mem_req_o, 1);
    tick();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_wait_stall", stall_o, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_req_after", mem_req_o, 0);
    chk("rstw_be_after", mem_be_o, 0);
    chk("rstw_addr_after", mem_addr_o, 0);
    chk("rstw_stall_after", stall_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h12345678;
    #1;
    chk("stray_valid", rdata_valid_o, 0);
    chk("stray_rdata", rdata_o, 0);
    chk("stray_stall", stall_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("stray_noreq", mem_req_o, 0);

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
